pipe_seg_skid: RTL and testbench

- Parametrised pipeline segment register with a valid/ready handshake and a 2-entry skid buffer.
- Placed between any two core stages (pd/id, id/ex, ...) in place of the fixed-field stall/refresh segment registers.
- The downstream stage's ready is never used combinationally toward upstream, so long stall paths are cut.
- Provides flush with priority over stall and a multi-cycle flush shadow flag, which generalises the one-cycle "fail flushed" marker.

---
 rtl/pipe_seg_skid.sv | 98 +++++++++
 tb/tb_pipe_seg_skid.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with a valid/ready handshake, 2-entry skid buffer,
// flush and a flush shadow flag. Define PIPE_SEG_STALL_CNT_EN to build the stall counter.
module pipe_seg_skid #(
    parameter int unsigned       DATA_W        = 64,
    parameter logic [DATA_W-1:0] RESET_VAL     = {DATA_W{1'b0}},
    parameter int unsigned       SHADOW_CYCLES = 1,
    parameter int unsigned       CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic              flush_shadow,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [7:0] SHADOW_LD = 8'(SHADOW_CYCLES);

    logic              r_out_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [7:0]        r_shadow;
    logic              w_in_fire;
    logic              w_out_fire;

    // in_ready comes straight from the skid flop, so out_ready never reaches upstream
    assign in_ready   = ~r_skid_valid;
    assign w_in_fire  = in_valid & ~r_skid_valid;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= RESET_VAL;
            r_skid_data  <= RESET_VAL;
            r_shadow     <= 8'd0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= RESET_VAL;
            r_skid_data  <= RESET_VAL;
            r_shadow     <= SHADOW_LD;
        end else begin
            if (r_shadow != 8'd0)
                r_shadow <= r_shadow - 8'd1;
            if (!r_out_valid) begin
                if (w_in_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                end
            end else if (w_out_fire) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= RESET_VAL;
                end else if (w_in_fire) begin
                    r_out_data <= in_data;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= RESET_VAL;
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign occupancy    = {r_out_valid & r_skid_valid, r_out_valid ^ r_skid_valid};
    assign flush_shadow = (r_shadow != 8'd0);

`ifdef PIPE_SEG_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles a held beat waits on downstream
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (r_out_valid && !out_ready && !flush && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Bench for pipe_seg_skid: directed vector table, hand sequences and random
// traffic against a queue-based reference model.
module tb_pipe_seg_skid;

    localparam int          DW   = 16;
    localparam logic [15:0] RV   = 16'hDEAD;
    localparam int          SH   = 3;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, flush_shadow;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    pipe_seg_skid #(.DATA_W(DW), .RESET_VAL(RV), .SHADOW_CYCLES(SH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .flush_shadow(flush_shadow), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of held beats (max 2), shadow countdown, stall count
    logic [DW-1:0] mq[$];
    int            m_sh  = 0;
    int            m_stc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] id, input logic ordy);
        bit mv, mir, infire, outfire;
        reset = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        mv      = (mq.size() > 0);
        mir     = (mq.size() < 2);
        infire  = iv && mir;
        outfire = mv && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete(); m_sh = 0; m_stc = 0;
        end else begin
            if (mv && !ordy && !f && m_stc < CMAX) m_stc++;
            if (f) begin
                mq.delete(); m_sh = SH;
            end else begin
                if (outfire) void'(mq.pop_front());
                if (infire) mq.push_back(id);
                if (m_sh > 0) m_sh--;
            end
        end
        chk("mdl_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("mdl_out_data", 32'(out_data), 32'(mq.size() > 0 ? mq[0] : RV));
        chk("mdl_occupancy", 32'(occupancy), 32'(mq.size()));
        chk("mdl_in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("mdl_flush_shadow", 32'(flush_shadow), 32'(m_sh > 0));
`ifdef PIPE_SEG_STALL_CNT_EN
        chk("mdl_stall_cnt", 32'(stall_cnt), 32'(m_stc));
`else
        chk("mdl_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    endtask

    typedef struct {
        logic          rst, fl, iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
        logic          e_ir, e_sh;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] id,
                       input logic ordy, input logic e_ov, input logic [DW-1:0] e_od,
                       input logic [1:0] e_occ, input logic e_ir, input logic e_sh);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir; v.e_sh = e_sh;
        tbl.push_back(v);
    endtask

    initial begin
        //   rst fl iv id       ordy ov od       occ ir sh
        add(1, 0, 0, 16'h0000, 0,  0, RV,       0,  1, 0);
        add(0, 0, 1, 16'h0011, 1,  1, 16'h0011, 1,  1, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 1, 16'(k), 1,  1, 16'(k),  1,  1, 0);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 0);
        add(0, 0, 1, 16'h000A, 0,  1, 16'h000A, 1,  1, 0);
        add(0, 0, 1, 16'h000B, 0,  1, 16'h000A, 2,  0, 0);
        add(0, 0, 1, 16'h000C, 0,  1, 16'h000A, 2,  0, 0);
        add(0, 0, 0, 16'h0000, 1,  1, 16'h000B, 1,  1, 0);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 0);
        add(0, 0, 1, 16'h000D, 0,  1, 16'h000D, 1,  1, 0);
        add(0, 0, 1, 16'h000E, 0,  1, 16'h000D, 2,  0, 0);
        add(0, 1, 1, 16'h000C, 0,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 0);
        add(0, 1, 1, 16'h000F, 1,  0, RV,       0,  1, 1);
        add(0, 1, 0, 16'h0000, 1,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 1);
        add(0, 0, 0, 16'h0000, 1,  0, RV,       0,  1, 0);
        add(0, 0, 1, 16'h0021, 0,  1, 16'h0021, 1,  1, 0);
        add(1, 1, 1, 16'h0022, 0,  0, RV,       0,  1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_flush_shadow", i), 32'(flush_shadow), 32'(tbl[i].e_sh));
        end

        // Held beat stalled for 20 cycles: counter saturates at all-ones
        step(0, 0, 1, 16'h0033, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 16'h0000, 0);
`ifdef PIPE_SEG_STALL_CNT_EN
        chk("stall_saturated", 32'(stall_cnt), 32'(CMAX));
`else
        chk("stall_tied_zero", 32'(stall_cnt), 32'd0);
`endif
        chk("stall_beat_held", 32'(out_data), 32'h0033);
        step(0, 0, 0, 16'h0000, 1);
        chk("stall_drain_valid", 32'(out_valid), 32'd0);

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 9) < 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
